// File: rtl/alu_control_pipe.sv
// Registered ALU control decoder with a one-entry valid/ready output stage.
// Define ALU_CTRL_M_EXT_EN to compile in RV32M decode and the multi-cycle busy sequencer.
module alu_control_pipe #(
  parameter int OP_W    = 5,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      alu_op_i,
  input  logic [2:0]      funct3_i,
  input  logic [6:0]      funct7_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [OP_W-1:0] alu_operation_o,
  output logic            illegal_o,
  output logic            busy_o
);

  if (OP_W < 5 || MUL_LAT < 1 || DIV_LAT < 1) begin : g_bad_params
    $error("alu_control_pipe: OP_W must be >= 5, MUL_LAT and DIV_LAT >= 1");
  end

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HOLD  = 2'd2;
`ifdef ALU_CTRL_M_EXT_EN
  localparam logic [1:0] MULTI = 2'd1;
`endif

  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_SUB  = 5'h01;
  localparam logic [4:0] OP_LUI  = 5'h02;
  localparam logic [4:0] OP_SLL  = 5'h04;
  localparam logic [4:0] OP_SRL  = 5'h05;
  localparam logic [4:0] OP_SRA  = 5'h0E;
  localparam logic [4:0] OP_BEQ  = 5'h08;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
`ifdef ALU_CTRL_M_EXT_EN
  localparam logic [6:0] F7_MEXT = 7'b0000001;
  localparam logic [4:0] OP_MUL  = 5'h11;
`endif

  // Handshake: a request is accepted when valid_i && ready_o && !flush_i;
  // the held code is consumed when valid_o && ready_i. Flush discards a same-cycle accept.

  // funct7 = 0 arithmetic table shared by R-type and I-arith.
  function automatic logic [4:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = OP_ADD;
      3'b001:  base_op = OP_SLL;
      3'b010:  base_op = 5'h0F;
      3'b011:  base_op = 5'h10;
      3'b100:  base_op = 5'h07;
      3'b101:  base_op = OP_SRL;
      3'b110:  base_op = 5'h03;
      default: base_op = 5'h06;
    endcase
  endfunction

  logic [1:0]      state_q, state_d;
  logic [OP_W-1:0] op_q;
  logic            illegal_q;
  logic [4:0]      dec_op;
  logic            dec_ill;
  logic            accept;
`ifdef ALU_CTRL_M_EXT_EN
  logic            dec_multi;
`endif

  always_comb begin
    dec_op  = OP_ADD;
    dec_ill = 1'b0;
`ifdef ALU_CTRL_M_EXT_EN
    dec_multi = 1'b0;
`endif
    case (alu_op_i)
      3'b000: begin
        if (funct7_i == F7_BASE) begin
          dec_op = base_op(funct3_i);
        end else if (funct7_i == F7_ALT) begin
          if (funct3_i == 3'b000)      dec_op = OP_SUB;
          else if (funct3_i == 3'b101) dec_op = OP_SRA;
          else                         dec_ill = 1'b1;
`ifdef ALU_CTRL_M_EXT_EN
        end else if (funct7_i == F7_MEXT) begin
          dec_op    = OP_MUL + {2'b00, funct3_i};
          dec_multi = 1'b1;
`endif
        end else begin
          dec_ill = 1'b1;
        end
      end
      3'b001: begin
        // Only the shift immediates carry funct7 meaning.
        if (funct3_i == 3'b001) begin
          if (funct7_i == F7_BASE) dec_op = OP_SLL;
          else                     dec_ill = 1'b1;
        end else if (funct3_i == 3'b101) begin
          if (funct7_i == F7_BASE)     dec_op = OP_SRL;
          else if (funct7_i == F7_ALT) dec_op = OP_SRA;
          else                         dec_ill = 1'b1;
        end else begin
          dec_op = base_op(funct3_i);
        end
      end
      3'b010: dec_op = OP_LUI;
      3'b011: begin
        case (funct3_i)
          3'b000:  dec_op = OP_BEQ;
          3'b001:  dec_op = 5'h09;
          3'b100:  dec_op = 5'h0A;
          3'b101:  dec_op = 5'h0B;
          3'b110:  dec_op = 5'h0C;
          3'b111:  dec_op = 5'h0D;
          default: dec_ill = 1'b1;
        endcase
      end
      3'b100, 3'b101: dec_op = OP_ADD;
      default: dec_ill = 1'b1;
    endcase
  end

  assign valid_o = (state_q == HOLD);
  assign ready_o = (state_q == IDLE) || ((state_q == HOLD) && ready_i);
  assign accept  = valid_i && ready_o && !flush_i;
  assign alu_operation_o = op_q;
  assign illegal_o       = illegal_q;

`ifdef ALU_CTRL_M_EXT_EN
  localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lat_sel;

  // funct3[2] separates the divide group from the multiply group.
  assign lat_sel = funct3_i[2] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
  assign busy_o  = (state_q == MULTI);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = dec_multi ? MULTI : HOLD;
            cnt_d   = dec_multi ? lat_sel : '0;
          end
        end
        MULTI: begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        HOLD: begin
          if (ready_i) begin
            if (accept) begin
              state_d = dec_multi ? MULTI : HOLD;
              cnt_d   = dec_multi ? lat_sel : '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign busy_o = 1'b0;

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = HOLD;
        HOLD:    if (ready_i) state_d = accept ? HOLD : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q      <= OP_W'(dec_op);
        illegal_q <= dec_ill;
      end
    end
  end

endmodule

// File: tb/tb_alu_control_pipe.sv
// Directed-vector bench for alu_control_pipe; expectations follow the build's ALU_CTRL_M_EXT_EN setting.
module tb_alu_control_pipe;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [2:0] alu_op_i = 3'b000;
  logic [2:0] funct3_i = 3'b000;
  logic [6:0] funct7_i = 7'b0000000;
  logic       flush_i = 1'b0;
  logic       valid_o;
  logic       ready_i = 1'b0;
  logic [4:0] alu_operation_o;
  logic       illegal_o;
  logic       busy_o;

  int tests_run = 0;
  int tests_failed = 0;

  logic [4:0] exp_q[$];

  // Observed bundle: {valid_o, busy_o, ready_o, illegal_o, alu_operation_o}
  logic [8:0] obs;
  assign obs = {valid_o, busy_o, ready_o, illegal_o, alu_operation_o};

  alu_control_pipe #(.OP_W(5), .MUL_LAT(2), .DIV_LAT(32)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
    .alu_op_i(alu_op_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
    .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
    .alu_operation_o(alu_operation_o), .illegal_o(illegal_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [2:0] f3, input logic [6:0] f7);
    valid_i  = 1'b1;
    alu_op_i = op;
    funct3_i = f3;
    funct7_i = f7;
  endtask

  task automatic test_reset();
    logic [8:0] exp;
    reset = 1'b0;
    #2;
    exp = {1'b0, 1'b0, 1'b1, 1'b0, 5'h00};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL reset_state: got %b exp %b", obs, exp);
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_multi();
    logic [8:0] exp;
    ready_i = 1'b1;
    drive(3'b000, 3'b100, 7'b0000001);
    tick();
    valid_i = 1'b0;
    repeat (9) tick();
`ifdef ALU_CTRL_M_EXT_EN
    exp = {1'b0, 1'b1, 1'b0, 1'b0, 5'h15};
`else
    exp = {1'b0, 1'b0, 1'b1, 1'b1, 5'h00};
`endif
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL div_in_progress: got %b exp %b", obs, exp);
    end
    #2;
    reset = 1'b0;
    #1;
    exp = {1'b0, 1'b0, 1'b1, 1'b0, 5'h00};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL async_reset_mid_multi: got %b exp %b", obs, exp);
    end
    #2;
    reset = 1'b1;
    tick();
    drive(3'b000, 3'b000, 7'b0000000);
    tick();
    valid_i = 1'b0;
    exp = {1'b1, 1'b0, 1'b1, 1'b0, 5'h00};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL add_after_reset: got %b exp %b", obs, exp);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [4:0] e;
    ready_i = 1'b1;
    exp_q.push_back(5'h01);
    exp_q.push_back(5'h0E);
    exp_q.push_back(5'h10);
    drive(3'b000, 3'b000, 7'b0100000);
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(3'b000, 3'b101, 7'b0100000);
      if (i == 1) drive(3'b000, 3'b011, 7'b0000000);
      if (i == 2) valid_i = 1'b0;
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== {1'b1, 1'b0, 1'b1, 1'b0, e}) begin
        tests_failed++;
        $display("FAIL back_to_back[%0d]: got %b exp %b", i, obs, {1'b1, 1'b0, 1'b1, 1'b0, e});
      end
      tick();
    end
    tests_run++;
    if (obs !== {1'b0, 1'b0, 1'b1, 1'b0, 5'h10}) begin
      tests_failed++;
      $display("FAIL back_to_back_drain: got %b exp %b", obs, {1'b0, 1'b0, 1'b1, 1'b0, 5'h10});
    end
  endtask

  typedef struct {
    logic [2:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] code;
    logic       ill;
  } vec_t;

  task automatic test_decode();
    vec_t tbl[16];
    tbl[0]  = '{3'b011, 3'b010, 7'h00, 5'h00, 1'b1};  // branch f3=010
    tbl[1]  = '{3'b001, 3'b001, 7'h20, 5'h00, 1'b1};  // SLLI with f7=0100000
    tbl[2]  = '{3'b010, 3'b111, 7'h7F, 5'h02, 1'b0};  // LUI
    tbl[3]  = '{3'b101, 3'b110, 7'h55, 5'h00, 1'b0};  // AUIPC
    tbl[4]  = '{3'b100, 3'b010, 7'h12, 5'h00, 1'b0};  // load/store
    tbl[5]  = '{3'b011, 3'b001, 7'h00, 5'h09, 1'b0};  // BNE
    tbl[6]  = '{3'b011, 3'b100, 7'h00, 5'h0A, 1'b0};  // BLT
    tbl[7]  = '{3'b011, 3'b110, 7'h00, 5'h0C, 1'b0};  // BLTU
    tbl[8]  = '{3'b001, 3'b101, 7'h00, 5'h05, 1'b0};  // SRLI
    tbl[9]  = '{3'b001, 3'b101, 7'h20, 5'h0E, 1'b0};  // SRAI
    tbl[10] = '{3'b001, 3'b010, 7'h7F, 5'h0F, 1'b0};  // SLTI, funct7 ignored
    tbl[11] = '{3'b001, 3'b101, 7'h01, 5'h00, 1'b1};  // SRLI bad funct7
    tbl[12] = '{3'b000, 3'b000, 7'h02, 5'h00, 1'b1};  // R unknown funct7
    tbl[13] = '{3'b000, 3'b001, 7'h20, 5'h00, 1'b1};  // R alt funct7, bad funct3
    tbl[14] = '{3'b110, 3'b000, 7'h00, 5'h00, 1'b1};  // unknown class
    tbl[15] = '{3'b000, 3'b111, 7'h00, 5'h06, 1'b0};  // AND
    ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].op, tbl[i].f3, tbl[i].f7);
      tick();
      tests_run++;
      if (obs !== {1'b1, 1'b0, 1'b1, tbl[i].ill, tbl[i].code}) begin
        tests_failed++;
        $display("FAIL decode[%0d]: got %b exp %b", i, obs, {1'b1, 1'b0, 1'b1, tbl[i].ill, tbl[i].code});
      end
    end
    valid_i = 1'b0;
    tick();
  endtask

  task automatic test_mul();
    logic [8:0] exp;
    ready_i = 1'b1;
    drive(3'b000, 3'b000, 7'b0000001);
    tick();
    valid_i = 1'b0;
`ifdef ALU_CTRL_M_EXT_EN
    for (int i = 1; i <= 2; i++) begin
      exp = {1'b0, 1'b1, 1'b0, 1'b0, 5'h11};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL mul_busy_cycle%0d: got %b exp %b", i, obs, exp);
      end
      tick();
    end
    exp = {1'b1, 1'b0, 1'b1, 1'b0, 5'h11};
`else
    exp = {1'b1, 1'b0, 1'b1, 1'b1, 5'h00};
`endif
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL mul_result: got %b exp %b", obs, exp);
    end
    tick();
    tests_run++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL mul_drain: got valid=%b busy=%b exp 0 0", valid_o, busy_o);
    end
  endtask

  task automatic test_stall();
    logic [8:0] exp;
    ready_i = 1'b0;
    drive(3'b011, 3'b111, 7'b0000000);
    tick();
    drive(3'b000, 3'b100, 7'b0000000);
    exp = {1'b1, 1'b0, 1'b0, 1'b0, 5'h0D};
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: got %b exp %b", i, obs, exp);
      end
      tick();
    end
    ready_i = 1'b1;
    #1;
    tests_run++;
    if (ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_release_ready: got %b exp 1", ready_o);
    end
    tick();
    valid_i = 1'b0;
    exp = {1'b1, 1'b0, 1'b1, 1'b0, 5'h07};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL stall_then_xor: got %b exp %b", obs, exp);
    end
    tick();
  endtask

  task automatic test_flush();
    logic [8:0] exp;
    ready_i = 1'b0;
    drive(3'b011, 3'b000, 7'b0000000);
    tick();
    drive(3'b000, 3'b100, 7'b0000000);
    ready_i = 1'b1;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    valid_i = 1'b0;
    exp = {1'b0, 1'b0, 1'b1, 1'b0, 5'h08};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL flush_hold: got %b exp %b", obs, exp);
    end
    tick();
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL flush_no_issue: got %b exp %b", obs, exp);
    end
`ifdef ALU_CTRL_M_EXT_EN
    drive(3'b000, 3'b110, 7'b0000001);
    tick();
    valid_i = 1'b0;
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    exp = {1'b0, 1'b0, 1'b1, 1'b0, 5'h17};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL flush_multi: got %b exp %b", obs, exp);
    end
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_reset_mid_multi();
    test_back_to_back();
    test_decode();
    test_mul();
    test_stall();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
